// File: rtl/wide_lane_pipe.sv
// wide_lane_pipe: two-stage valid/ready pipeline computing a per-nibble
// bitwise function of operands A and B. Bits above the nibble field pass
// B straight through.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   upstream handshake
//   in_mode             0: A = in_a, 1: A = CONST_A (travels with its txn)
//   in_a, in_b          W-bit operands
//   out_valid/out_ready downstream handshake
//   out_c               W-bit result, held while stalled
//   txn_count           completed output handshakes, wraps at 16 bits
module wide_lane_pipe #(
  parameter int NIB    = 9,
  parameter int PASS_W = 29,
  localparam int W     = 4 * NIB + PASS_W,
  parameter logic [W-1:0] CONST_A = W'(65'h1_00000002_00000002)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_c,
  output logic [15:0]  txn_count
);

  logic                 s1_valid;
  logic                 s1_mode;
  logic [4*NIB-1:0]     s1_a;
  logic [W-1:0]         s1_b;
  logic                 s2_valid;
  logic [W-1:0]         s2_c;

  logic                 adv2;
  logic                 accept;
  logic                 move;
  logic [4*NIB-1:0]     a_eff;
  logic [4*NIB-1:0]     c_nib;
  logic [W-1:0]         c_nxt;

  // S2 can take new data when empty or draining; S1 likewise relative to S2,
  // so an empty stage never blocks the one upstream of it.
  assign adv2     = !s2_valid || out_ready;
  assign in_ready = !s1_valid || adv2;
  assign accept   = in_valid && in_ready;
  assign move     = s1_valid && adv2;

  assign out_valid = s2_valid;
  assign out_c     = s2_c;

  always_comb begin
    a_eff = s1_mode ? CONST_A[4*NIB-1:0] : s1_a;
    c_nib = '0;
    for (int n = 0; n < NIB; n++) begin
      c_nib[4*n]   = ~a_eff[4*n];
      c_nib[4*n+1] = ~s1_b[4*n];
      c_nib[4*n+2] = ~s1_b[4*n+1];
      c_nib[4*n+3] = ~((a_eff[4*n+1] | a_eff[4*n+2]) &
                       (s1_b[4*n+1]  | s1_b[4*n+2])  &
                       (a_eff[4*n+3] | s1_b[4*n+3]));
    end
  end

  generate
    if (PASS_W > 0) begin : g_pass
      // Upper A bits never reach the result.
      logic unused_a_hi;
      assign unused_a_hi = ^in_a[W-1:4*NIB];
      assign c_nxt = {s1_b[W-1:4*NIB], c_nib};
    end else begin : g_nopass
      assign c_nxt = c_nib;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_mode   <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s2_valid  <= 1'b0;
      s2_c      <= '0;
      txn_count <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (accept) begin
        s1_mode <= in_mode;
        s1_a    <= in_a[4*NIB-1:0];
        s1_b    <= in_b;
      end
      if (adv2) s2_valid <= s1_valid;
      // Only load on a real transfer so out_c stays put while stalled.
      if (move) s2_c <= c_nxt;
      if (s2_valid && out_ready) txn_count <= txn_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_wide_lane_pipe.sv
module tb_wide_lane_pipe;

  localparam int NIB    = 9;
  localparam int PASS_W = 29;
  localparam int W      = 4 * NIB + PASS_W;
  localparam logic [W-1:0] CONST_A = 65'h1_00000002_00000002;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         in_mode;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_c;
  logic [15:0]  txn_count;

  wide_lane_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .txn_count (txn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  int           n_vec = 0;
  int           n_err = 0;
  int           stall_waits = 0;
  logic [W-1:0] cur_exp = '0;
  logic [W-1:0] q[$];
  logic [W-1:0] ones = '1;
  logic [W-1:0] held;
  vec_t         tbl[10];
  vec_t         sv[8];

  function automatic logic [W-1:0] model(input logic m, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W-1:0] ap;
    logic [W-1:0] c;
    ap = m ? CONST_A : a;
    c  = b;
    for (int n = 0; n < NIB; n++) begin
      c[4*n]   = ~ap[4*n];
      c[4*n+1] = ~b[4*n];
      c[4*n+2] = ~b[4*n+1];
      c[4*n+3] = ~((ap[4*n+1] | ap[4*n+2]) & (b[4*n+1] | b[4*n+2]) & (ap[4*n+3] | b[4*n+3]));
    end
    return c;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: push on accept, pop/compare on output handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: got %h expected no output", out_c);
        end else begin
          check("scoreboard", out_c, q.pop_front());
        end
      end
      if (in_valid && in_ready) q.push_back(cur_exp);
    end
  end

  task automatic set_in(input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] e);
    in_valid = 1'b1;
    in_mode  = m;
    in_a     = a;
    in_b     = b;
    cur_exp  = e;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] e);
    int w;
    w = 0;
    set_in(m, a, b, e);
    @(negedge clk);
    while (!in_ready && w < 50) begin
      w++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 within 50 cycles");
    end
    stall_waits += w;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
    check("sb_empty", W'(q.size()), '0);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 0; in_mode = 0; in_a = '0; in_b = '0; out_ready = 1; rst_n = 0;

    tbl[0] = '{1'b0, '0, '0, 65'h0_0000000F_FFFFFFFF};
    tbl[1] = '{1'b0, ones, ones, 65'h1_FFFFFFF0_00000000};
    tbl[2] = '{1'b1, rnd(), '0, 65'h0_0000000F_FFFFFFFF};
    tbl[3] = '{1'b1, rnd(), ones, 65'h1_FFFFFFF1_99999991};
    tbl[4] = '{1'b1, rnd(), ones, 65'h1_FFFFFFF1_99999991};
    for (int i = 5; i < 10; i++) begin
      tbl[i].mode = i[0];
      tbl[i].a    = rnd();
      tbl[i].b    = rnd();
      tbl[i].exp  = model(tbl[i].mode, tbl[i].a, tbl[i].b);
    end
    for (int i = 0; i < 8; i++) begin
      sv[i].mode = i[1];
      sv[i].a    = rnd();
      sv[i].b    = rnd();
      sv[i].exp  = model(sv[i].mode, sv[i].a, sv[i].b);
    end

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", W'(out_valid), '0);
    check("rst_out_c", out_c, '0);
    check("rst_txn_count", W'(txn_count), '0);
    check("rst_in_ready", W'(in_ready), W'(1));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single transaction latency.
    set_in(1'b0, '0, '0, 65'h0_0000000F_FFFFFFFF);
    @(negedge clk);
    check("lat_accept", W'(in_ready), W'(1));
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    check("lat_cycle1_valid", W'(out_valid), '0);
    @(negedge clk);
    check("lat_cycle2_valid", W'(out_valid), W'(1));
    check("lat_cycle2_c", out_c, 65'h0_0000000F_FFFFFFFF);
    @(posedge clk); #1;
    check("lat_txn_count", W'(txn_count), W'(1));

    // Table vectors, back-to-back with mixed modes.
    stall_waits = 0;
    for (int i = 0; i < 10; i++) send(tbl[i].mode, tbl[i].a, tbl[i].b, tbl[i].exp);
    idle();
    drain();
    check("throughput_waits", W'(stall_waits), '0);
    check("table_txn_count", W'(txn_count), W'(11));

    // Backpressure: stall with a full pipe, then release.
    do_reset();
    out_ready = 1'b0;
    send(sv[0].mode, sv[0].a, sv[0].b, sv[0].exp);
    send(sv[1].mode, sv[1].a, sv[1].b, sv[1].exp);
    set_in(sv[2].mode, sv[2].a, sv[2].b, sv[2].exp);
    @(negedge clk);
    check("full_in_ready", W'(in_ready), '0);
    check("full_out_valid", W'(out_valid), W'(1));
    held = out_c;
    check("full_head_c", out_c, sv[0].exp);
    repeat (5) begin
      @(negedge clk);
      check("stall_hold_c", out_c, held);
      check("stall_in_ready", W'(in_ready), '0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 2; i < 8; i++) send(sv[i].mode, sv[i].a, sv[i].b, sv[i].exp);
    idle();
    drain();
    check("stall_txn_count", W'(txn_count), W'(8));

    // txn_count wrap.
    do_reset();
    set_in(1'b0, '0, '0, 65'h0_0000000F_FFFFFFFF);
    repeat (65534) @(posedge clk);
    #1;
    idle();
    drain();
    check("preload_txn_count", W'(txn_count), W'(16'hFFFE));
    for (int i = 0; i < 3; i++) send(tbl[i].mode, tbl[i].a, tbl[i].b, tbl[i].exp);
    idle();
    drain();
    check("wrap_txn_count", W'(txn_count), W'(1));

    // Reset with transactions in flight.
    do_reset();
    for (int i = 0; i < 3; i++) send(sv[i].mode, sv[i].a, sv[i].b, sv[i].exp);
    idle();
    drain();
    out_ready = 1'b0;
    send(sv[3].mode, sv[3].a, sv[3].b, sv[3].exp);
    send(sv[4].mode, sv[4].a, sv[4].b, sv[4].exp);
    idle();
    check("inflight_valid", W'(out_valid), W'(1));
    check("inflight_txn_count", W'(txn_count), W'(3));
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", W'(out_valid), '0);
    check("midrst_txn_count", W'(txn_count), '0);
    check("midrst_out_c", out_c, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_no_output", W'(out_valid), '0);
    end
    @(posedge clk); #1;
    send(tbl[9].mode, tbl[9].a, tbl[9].b, tbl[9].exp);
    idle();
    drain();
    check("post_rst_txn_count", W'(txn_count), W'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wide_lane_pipe.md
WIDE_LANE_PIPE -- requirements
Module: wide_lane_pipe

Interface
REQ-001 The block SHALL have parameter NIB, default 9: number of 4-bit logic nibbles, with NIB >= 1.
REQ-002 The block SHALL have parameter PASS_W, default 29: number of pass-through bits above the nibble field, with PASS_W >= 0.
REQ-003 The block SHALL have parameter CONST_A, width W, default 65'h1_00000002_00000002: the substitute A operand used in constant mode.
REQ-004 The block SHALL use the derived width W = 4*NIB + PASS_W (65 at defaults).
REQ-005 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 in_valid  input  1  a transaction is offered.
REQ-008 in_ready  output  1  the block accepts the transaction this cycle.
REQ-009 in_mode  input  1  0 = use in_a; 1 = use CONST_A; sampled with the transaction.
REQ-010 in_a  input  W  operand A.
REQ-011 in_b  input  W  operand B.
REQ-012 out_valid  output  1  out_c holds a valid result.
REQ-013 out_ready  input  1  the downstream consumer accepts the result.
REQ-014 out_c  output  W  result.
REQ-015 txn_count  output  16  count of completed output handshakes.

Function
REQ-016 For nibble n (0..NIB-1), with operand A' (in_a or CONST_A), the block SHALL compute:
 - c[4n] = ~A'[4n]
 - c[4n+1] = ~b[4n]
 - c[4n+2] = ~b[4n+1]
 - c[4n+3] = ~((A'[4n+1]|A'[4n+2]) & (b[4n+1]|b[4n+2]) & (A'[4n+3]|b[4n+3]))
REQ-017 Bits c[W-1:4*NIB] SHALL equal b[W-1:4*NIB]; when PASS_W = 0 this field SHALL be absent.
REQ-018 The pipeline SHALL have two stages: S1 registers {mode, a, b}; S2 registers the computed c. Latency from accept to out_valid SHALL be exactly 2 cycles when out_ready = 1 throughout.
REQ-019 The stall rule SHALL be adv2 = !s2_valid | out_ready, in_ready = !s1_valid | adv2, and S1 SHALL move to S2 only when s1_valid & adv2.
REQ-020 Bubbles SHALL collapse: an empty stage never blocks the stage upstream of it.
REQ-021 A transaction SHALL be accepted only when in_valid & in_ready, and each accepted transaction SHALL produce exactly one result, in order, with none lost or duplicated.
REQ-022 While out_valid = 1 and out_ready = 0, out_c SHALL hold stable.
REQ-023 in_ready SHALL NOT depend combinationally on in_valid.
REQ-024 Sustained throughput SHALL be 1 transaction per cycle when out_ready = 1.
REQ-025 txn_count SHALL increment on each out_valid & out_ready and wrap from 16'hFFFF to 0.
REQ-026 When accept and drain occur in the same cycle with the pipeline full, the block SHALL proceed with no bubble and no loss.
REQ-027 in_mode SHALL travel with its own transaction, so a mode change between back-to-back transactions affects only the later one.

Reset
REQ-028 While rst_n = 0, the block SHALL force s1_valid = 0, s2_valid = 0, out_valid = 0, out_c = 0, txn_count = 0, and in_ready = 1 after reset.
REQ-029 Assertion of rst_n mid-operation SHALL discard all in-flight transactions immediately, and no result SHALL appear after deassertion unless a new accept occurs.
REQ-030 Deassertion SHALL be synchronised externally, and the first accept SHALL be possible on the first rising edge with rst_n = 1.

Verification
REQ-031 Defaults, mode 0, a = 0, b = 0, out_ready = 1 -> out_c = 65'h0_0000000F_FFFFFFFF exactly 2 cycles later, and txn_count = 1.
REQ-032 Mode 0, a = b = all-ones -> out_c = 65'h1_FFFFFFF0_00000000.
REQ-033 Mode 1, a = random, b = 0 -> out_c equals the REQ-016/017 model evaluated with CONST_A, independent of in_a.
REQ-034 Stream 8 back-to-back transactions, hold out_ready = 0 for 5 cycles, then release -> in_ready falls after 2 accepts, out_c stays stable while stalled, all 8 results arrive in order, and txn_count = 8.
REQ-035 Preload txn_count to 16'hFFFE via 16'hFFFE handshakes (or force), then complete 3 more -> txn_count = 1.
REQ-036 Pulse rst_n low with 2 transactions in flight -> out_valid = 0 and txn_count = 0 immediately, and no stale output appears afterwards.
